// File: rtl/ipsxe_floating_point_pkg_v1_0.sv
// Shared helpers for the floating-point support blocks:
// log2 helper and derived widths of the leading-one finder.
package ipsxe_floating_point_pkg_v1_0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int calc_pw(input int w);
        return 1 << clog2(w);
    endfunction

    function automatic int calc_l(input int w);
        return clog2(calc_pw(w));
    endfunction

    function automatic int calc_idx_w(input int w);
        return (calc_l(w) < 1) ? 1 : calc_l(w);
    endfunction

    function automatic int calc_lzc_w(input int w);
        return clog2(w + 1);
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_PW    = calc_pw(DEF_WIDTH);
    localparam int DEF_L     = calc_l(DEF_WIDTH);
    localparam int DEF_IDX_W = calc_idx_w(DEF_WIDTH);
    localparam int DEF_LZC_W = calc_lzc_w(DEF_WIDTH);

endpackage

// File: rtl/ipsxe_floating_point_find_one_norm_v1_0_level.sv
// One bisection level: resolves one index bit, narrows the
// search window and pre-shifts the word towards the MSB.
module ipsxe_floating_point_find_one_level_v1_0 #(
    parameter int PW    = 32,
    parameter int WIN   = 32,
    parameter int IDX_W = 5,
    parameter int BIT   = 4,
    parameter int TAG_W = 1,
    parameter int REG   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clken,
    input  logic             i_valid,
    input  logic [WIN-1:0]   i_win,
    input  logic [PW-1:0]    i_word,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [WIN/2-1:0] o_win,
    output logic [PW-1:0]    o_word,
    output logic [IDX_W-1:0] o_idx,
    output logic [TAG_W-1:0] o_tag
);
    localparam int HALF = WIN / 2;

    logic             hi;
    logic [HALF-1:0]  win_n;
    logic [PW-1:0]    word_n;
    logic [IDX_W-1:0] idx_n;

    assign hi     = |i_win[WIN-1:HALF];
    assign win_n  = hi ? i_win[WIN-1:HALF] : i_win[HALF-1:0];
    assign word_n = hi ? i_word : (i_word << HALF);
    assign idx_n  = i_idx | (IDX_W'(hi) << BIT);

    if (REG != 0) begin : g_reg
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                o_valid <= 1'b0;
                o_win   <= '0;
                o_word  <= '0;
                o_idx   <= '0;
                o_tag   <= '0;
            end else if (i_clken) begin
                o_valid <= i_valid;
                o_win   <= win_n;
                o_word  <= word_n;
                o_idx   <= idx_n;
                o_tag   <= i_tag;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = i_clk ^ i_rst_n ^ i_clken;
        assign o_valid = i_valid;
        assign o_win   = win_n;
        assign o_word  = word_n;
        assign o_idx   = idx_n;
        assign o_tag   = i_tag;
    end

endmodule

// File: rtl/ipsxe_floating_point_find_one_norm_v1_0.sv
// Pipelined leading-one finder and normaliser of any width,
// built as a chain of bisection levels, front-loaded registers.
module ipsxe_floating_point_find_one_norm_v1_0
    import ipsxe_floating_point_pkg_v1_0::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_clken,
    input  logic                            i_valid,
    input  logic [WIDTH-1:0]                i_din,
    input  logic [TAG_W-1:0]                i_tag,
    output logic                            o_valid,
    output logic [calc_idx_w(WIDTH)-1:0]    o_index,
    output logic [calc_lzc_w(WIDTH)-1:0]    o_lzc,
    output logic                            o_zero,
    output logic [WIDTH-1:0]                o_norm,
    output logic [TAG_W-1:0]                o_tag
);
    localparam int PW    = calc_pw(WIDTH);
    localparam int L     = calc_l(WIDTH);
    localparam int IDX_W = calc_idx_w(WIDTH);
    localparam int LZC_W = calc_lzc_w(WIDTH);

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int WIN = PW >> (j - 1);

        logic             v_i, v_o;
        logic [WIN-1:0]   w_i;
        logic [WIN/2-1:0] w_o;
        logic [PW-1:0]    d_i, d_o;
        logic [IDX_W-1:0] x_i, x_o;
        logic [TAG_W-1:0] t_i, t_o;

        // Zero-extension at the top keeps the pad out of the index.
        if (j == 1) begin : g_head
            assign v_i = i_valid;
            assign w_i = PW'(i_din);
            assign d_i = PW'(i_din);
            assign x_i = '0;
            assign t_i = i_tag;
        end else begin : g_link
            assign v_i = g_lvl[j-1].v_o;
            assign w_i = g_lvl[j-1].w_o;
            assign d_i = g_lvl[j-1].d_o;
            assign x_i = g_lvl[j-1].x_o;
            assign t_i = g_lvl[j-1].t_o;
        end

        ipsxe_floating_point_find_one_level_v1_0 #(
            .PW    (PW),
            .WIN   (WIN),
            .IDX_W (IDX_W),
            .BIT   (L - j),
            .TAG_W (TAG_W),
            .REG   ((j <= LATENCY) ? 1 : 0)
        ) u_lvl (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clken (i_clken),
            .i_valid (v_i),
            .i_win   (w_i),
            .i_word  (d_i),
            .i_idx   (x_i),
            .i_tag   (t_i),
            .o_valid (v_o),
            .o_win   (w_o),
            .o_word  (d_o),
            .o_idx   (x_o),
            .o_tag   (t_o)
        );
    end

    logic [PW-1:0]    fin_word;
    logic [IDX_W-1:0] fin_idx;
    logic             fin_bit;
    logic             unused_word;

    assign fin_word    = g_lvl[L].d_o;
    assign fin_idx     = g_lvl[L].x_o;
    assign fin_bit     = g_lvl[L].w_o[0];
    assign unused_word = ^fin_word;

    assign o_valid = g_lvl[L].v_o;
    assign o_tag   = g_lvl[L].t_o;
    assign o_index = fin_idx;
    assign o_zero  = (fin_idx == '0) && !fin_bit;
    assign o_norm  = fin_word[PW-1 -: WIDTH];
    assign o_lzc   = o_zero ? LZC_W'(WIDTH)
                   : LZC_W'(WIDTH - 1) - LZC_W'(fin_idx);

endmodule

// File: doc/ipsxe_floating_point_find_one_norm_v1_0.md
Name: ipsxe_floating_point_find_one_norm_v1_0

Overview:
- Parametrised, pipelined leading-one detector and normaliser for the floating-point add/sub and convert paths.
- Per input word, returns four results:
  - leading-one bit index
  - leading-zero count
  - all-zero flag
  - input left-shifted so its leading one sits at the MSB
- Generalises the fixed 32-bit finder: any width, selectable latency, valid/tag tracking, integrated normalisation.

Parameters:
- WIDTH, 32, input data width; 2..64; need not be a power of two.
- LATENCY, 3, register stages from input to output; 0..L, where PW = 2^clog2(WIDTH), L = clog2(PW).
- TAG_W, 1, width of sideband tag carried alongside data; >=1.

Ports:
- i_clk  in  1  clock; all registers on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clken  in  1  pipeline advance enable; low freezes every register.
- i_valid  in  1  i_din/i_tag qualify this cycle.
- i_din  in  WIDTH  operand.
- i_tag  in  TAG_W  sideband, passed through unchanged.
- o_valid  out  1  outputs below qualify this cycle.
- o_index  out  IDX_W=max(1,L)  bit position of leading one; 0 when zero.
- o_lzc  out  LZC_W=clog2(WIDTH+1)  leading zeros = WIDTH-1-o_index; WIDTH when zero.
- o_zero  out  1  i_din was all zeros.
- o_norm  out  WIDTH  i_din << o_lzc truncated to WIDTH; 0 when zero.
- o_tag  out  TAG_W  delayed i_tag.

Behaviour:
- Padding: i_din zero-extended at the MSB side to PW bits, so index is unaffected by the pad.
- Bisection over L levels. Level j (j=1..L) halves the current window of size PW>>(j-1):
  - index bit L-j = OR of upper half.
  - Window for the next level = upper half if that bit is 1, else lower half.
- Normalisation runs in parallel with bisection:
  - At level j, if index bit L-j = 0, the shifted word shifts left by PW>>j.
  - After L levels the leading one is at bit PW-1.
  - o_norm = bits [PW-1 -: WIDTH] of that word.
- Register placement: a stage register follows level j for j=1..LATENCY (front-loaded). Each stage register holds:
  - remaining window
  - shifted word
  - resolved index bits
  - valid
  - tag
- Stages after LATENCY are combinational.
- o_lzc and o_zero are derived combinationally from the final stage: zero = no index bit set AND final window bit 0.
- Latency: exactly LATENCY enabled cycles from input to output.
  - LATENCY=0: fully combinational, o_valid = i_valid.
- i_clken=0: no register changes, outputs hold. A result in flight is neither lost nor duplicated.
- Valid stages capture i_valid every enabled cycle. Data stages capture regardless of valid; o_index/o_lzc/o_norm are don't-care when o_valid=0.
- Reset: asynchronous assert, all stage registers cleared. Reset state of every output:
  - o_valid=0, o_index=0, o_norm=0, o_tag=0, o_zero=1, o_lzc=WIDTH
  - With LATENCY=0 the outputs follow inputs instead.
- Reset mid-operation: in-flight results are discarded. The first o_valid after release is the first post-reset i_valid, arriving LATENCY enabled cycles later.
- No backpressure: the block accepts one word per enabled cycle, throughput 1.
- Boundaries:
  - din = 1 gives index 0, o_zero=0; distinguished from zero input only by o_zero.
  - MSB set gives lzc 0, norm = din.

Decomposition:
- Shared package ipsxe_floating_point_pkg_v1_0 holds:
  - clog2 function
  - derived-width constants PW, L, IDX_W, LZC_W
- Natural sub-module: ipsxe_floating_point_find_one_level_v1_0, one bisection/shift level. Parameters are window size and REG (0/1). It is instantiated L times by a generate loop, with REG = (j <= LATENCY).

Test Plan:
- WIDTH=32, LATENCY=3: din=32'h0001_0000, valid=1 -> 3 cycles later o_valid=1, index=16, lzc=15, zero=0, norm=32'h8000_0000.
- WIDTH=32, LATENCY=3: din=0 -> index=0, lzc=32, zero=1, norm=0. Then din=1 -> index=0, lzc=31, zero=0, norm=32'h8000_0000.
- WIDTH=24, LATENCY=2: din=24'h00_0003 -> index=1, lzc=22, norm=24'hC0_0000. Also din=24'h80_0000 -> index=23, lzc=0, norm=24'h80_0000.
- Streaming with stalls, WIDTH=32, LATENCY=3, tags 1..8 back-to-back:
  - Enable pattern: i_clken low for 2 cycles after the 3rd word.
  - Outputs appear in order with matching tags, no gaps or repeats apart from the stall.
  - Outputs hold during the stall.
- Reset mid-flight: assert i_rst_n low with 2 words in flight -> o_valid=0, o_norm=0 immediately (asynchronous). After release, only the new word emerges, 3 cycles later.
- Randomised sweep, LATENCY 0..L, WIDTH in {7,16,32,53,64} -> every output equals reference model (priority encode, shift) at delay LATENCY.
